alu_seq_unit: RTL and testbench
===============================

# alu_seq_unit

Parametrised multi-cycle ALU with built-in operation decode. It is the successor to the single-cycle ALU control path: it decodes the datapath's ALUOp/function fields and executes the single-cycle ops (add, sub, and, or, slt) in one clock. It adds an iterative shift-add multiply behind a start/busy/done handshake. It sits in the execute stage of the multi-cycle CPU, and the controller FSM stalls on `busy`.

## Interface
- `WIDTH`, 32: operand/result width, ≥ 2.
- `HAS_MUL`, 1: 1 = MUL supported; 0 = MUL function code is illegal.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: operation request; sampled only when `busy`=0.
- `alu_op` input 2: 00 add, 01 sub, 10 slt, 11 decode `funct`.
- `funct` input 6: one-hot function. 000001 ADD, 000010 SUB, 000100 AND, 001000 OR, 010000 SLT, 100000 MUL.
- `a`, `b` input WIDTH: operands; sampled on the accepting edge only.
- `result` output WIDTH: registered result; held until the next completion.
- `zero` output 1: registered, `result`==0.
- `ovf` output 1: registered signed overflow; add/sub only, else 0.
- `err` output 1: registered; completed op was illegal.
- `busy` output 1: MUL in progress.
- `done` output 1: one-cycle completion pulse.

## Operation
- Reset values: `result`=0, `zero`=1, `ovf`=0, `err`=0, `busy`=0, `done`=0, state IDLE.
- States: IDLE, MUL.
- IDLE with `start`=1 and a single-cycle op:
  - The op is computed and `result`/`zero`/`ovf`/`err` are registered on that edge.
  - `done`=1 for the next cycle.
  - State stays IDLE, so back-to-back starts are accepted every cycle.
- IDLE with `start`=1 and MUL (`alu_op`=11, `funct`=100000, `HAS_MUL`=1):
  - Load multiplicand=`a`, multiplier=`b`, acc=0, count=WIDTH.
  - Go to MUL; `busy`=1.
- MUL, each edge:
  - If multiplier[0], acc += multiplicand.
  - multiplicand <<= 1; multiplier >>= 1; count −1.
  - On the edge where count goes 1→0: `result` = final acc, `zero` updated, `ovf`=0, `err`=0, `done` pulses, return to IDLE, `busy`=0.
- Illegal op (`alu_op`=11 with a non-listed or multi-hot `funct`, or MUL with `HAS_MUL`=0):
  - Completes as a single-cycle op with `result`=0, `zero`=1, `err`=1.
- `start` while `busy`=1 is ignored; no queueing.
- `err` and `ovf` persist with `result` until the next completion.
- Arithmetic:
  - add/sub are modulo 2^WIDTH.
  - `ovf` is signed overflow: operand signs agree (add) or differ (sub), and the result sign differs from `a`.
  - slt is signed; result = {WIDTH−1 zeros, a<b}.
  - MUL gives the low WIDTH bits of the product, which is sign-agnostic.
- `rst_n` asserted mid-MUL aborts immediately to the reset values; no `done`.

## Timing
- Single-cycle op: `done` high 1 clock after the accepting edge.
- MUL: `busy` high for exactly WIDTH cycles. `done` and `result` are valid WIDTH clocks after the accepting edge, and `busy` falls in the same cycle `done` rises.
- A new `start` is accepted in the cycle `done` is high; the next completion follows the rules above.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `alu_seq_pkg`:
  - ALUOp codes and one-hot `funct` localparams.
  - Internal op enum: ADD, SUB, AND, OR, SLT, MUL, ILL.
  - State enum: IDLE, MUL.
- Sub-module `alu_seq_decode`: combinational mapping of `alu_op`/`funct`/`HAS_MUL` to the op enum (ILL on anything unlisted). It is reused by the pipelined CPU.
- Count register width is $clog2(WIDTH+1).

## Test plan
- Reset during MUL at cycle 5 of 32:
  - Outputs return to reset values asynchronously.
  - No `done` follows.
  - The next ADD is accepted normally.
- WIDTH=32, back-to-back single-cycle ops, `alu_op`=11:
  - ADD 7+5 → 12.
  - SUB 5−7 → 0xFFFFFFFE, `zero`=0.
  - AND 0xF0F0&0xFF00 → 0xF000.
  - OR → 0xFFF0.
  - SLT −1<1 → 1.
  - Each `done` arrives 1 clock after its start.
- Overflow and zero flags:
  - ADD 0x7FFFFFFF+1 → 0x80000000, `ovf`=1.
  - SUB 0x80000000−1 → `ovf`=1.
  - SUB 9−9 → `zero`=1, `ovf`=0.
- MUL 0x0001_2345 × 0x0000_0100 (WIDTH=32):
  - `busy` high for 32 cycles; `start` pulses during `busy` are ignored.
  - `done` at +32 with `result`=0x0123_4500.
  - MUL −3×7 → 0xFFFFFFEB.
- Illegal ops:
  - `funct`=000011 → `err`=1, `result`=0, `done` at +1.
  - MUL with `HAS_MUL`=0 (WIDTH=8 build) → `err`=1.
  - The following ADD clears `err`.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared codes and types for the sequential ALU
// Contents: ALUOp codes, one-hot funct codes, internal op enum, FSM state enum.
package alu_seq_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_SLT   = 2'b10;
  localparam logic [1:0] ALUOP_FUNCT = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b000001;
  localparam logic [5:0] FN_SUB = 6'b000010;
  localparam logic [5:0] FN_AND = 6'b000100;
  localparam logic [5:0] FN_OR  = 6'b001000;
  localparam logic [5:0] FN_SLT = 6'b010000;
  localparam logic [5:0] FN_MUL = 6'b100000;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLT,
    OP_MUL,
    OP_ILL
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

endpackage

// File: rtl/alu_seq_unit_if.sv
// rtl/alu_seq_unit_if.sv - request/response bundle between controller and ALU
// master: controller side (drives start/alu_op/funct/a/b, reads results).
// slave : ALU side (reads the request, drives result/zero/ovf/err/busy/done).
interface alu_seq_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             err;
  logic             busy;
  logic             done;

  modport master (
    output start, alu_op, funct, a, b,
    input  result, zero, ovf, err, busy, done
  );

  modport slave (
    input  start, alu_op, funct, a, b,
    output result, zero, ovf, err, busy, done
  );

endinterface

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational ALUOp/funct decode to internal op
// Ports: alu_op, funct in; op out (OP_ILL for anything not listed).
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter bit HAS_MUL = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output op_e        op
);

  always_comb begin
    op = OP_ILL;
    case (alu_op)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_SLT: op = OP_SLT;
      default: begin
        // funct must be exactly one of the listed one-hot codes;
        // zero or multi-hot patterns fall through to OP_ILL.
        case (funct)
          FN_ADD:  op = OP_ADD;
          FN_SUB:  op = OP_SUB;
          FN_AND:  op = OP_AND;
          FN_OR:   op = OP_OR;
          FN_SLT:  op = OP_SLT;
          FN_MUL: begin
            if (HAS_MUL) op = OP_MUL;
            else         op = OP_ILL;
          end
          default: op = OP_ILL;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - multi-cycle ALU: single-cycle ops plus shift-add MUL
// Ports: clk, rst_n (async, active-low), bus (alu_seq_unit_if.slave).
// Single-cycle ops complete on the accepting edge; MUL iterates WIDTH edges
// with busy high, then pulses done with the low WIDTH bits of the product.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit HAS_MUL = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  op_e              op;
  state_e           state;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic             sc_err;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic             err_q;
  logic             busy_q;
  logic             done_q;

  assign a_in = bus.a;
  assign b_in = bus.b;

  alu_seq_decode #(
    .HAS_MUL(HAS_MUL)
  ) u_decode (
    .alu_op(bus.alu_op),
    .funct (bus.funct),
    .op    (op)
  );

  assign sum  = a_in + b_in;
  assign diff = a_in - b_in;
  assign slt  = $signed(a_in) < $signed(b_in);

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_err = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (diff[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_AND: sc_res = a_in & b_in;
      OP_OR:  sc_res = a_in | b_in;
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, slt};
      OP_ILL: sc_err = 1'b1;
      default: sc_res = '0;
    endcase
  end

  // One shift-add step; also the value registered as the result on the last step.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (op == OP_MUL) begin
              mcand  <= a_in;
              mplier <= b_in;
              acc    <= '0;
              count  <= CW'(WIDTH);
              busy_q <= 1'b1;
              state  <= ST_MUL;
            end else begin
              result_q <= sc_res;
              zero_q   <= (sc_res == '0);
              ovf_q    <= sc_ovf;
              err_q    <= sc_err;
              done_q   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          if (count == CW'(1)) begin
            result_q <= acc_next;
            zero_q   <= (acc_next == '0);
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.ovf    = ovf_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - self-checking bench for alu_seq_unit (32-bit MUL build, 8-bit no-MUL build)
module tb_alu_seq_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_unit_if #(.WIDTH(32)) bus32 ();
  alu_seq_unit_if #(.WIDTH(8))  bus8 ();

  alu_seq_unit #(.WIDTH(32), .HAS_MUL(1'b1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  alu_seq_unit #(.WIDTH(8),  .HAS_MUL(1'b0)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        e;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res, input logic z,
                              input logic o, input logic e);
    vec_t v;
    v.op = op; v.fn = fn; v.a = a; v.b = b; v.res = res; v.z = z; v.o = o; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on 64-bit values, masked to w bits.
  function automatic void model(input int w, input bit has_mul, input logic [1:0] op,
                                input logic [5:0] fn, input logic [63:0] ua_in,
                                input logic [63:0] ub_in, output logic [63:0] res,
                                output bit ovf, output bit err, output bit is_mul);
    logic [63:0] mask, ua, ub;
    longint sa, sb, s, maxv, minv;
    int kind;
    mask = (64'd1 << w) - 64'd1;
    ua = ua_in & mask;
    ub = ub_in & mask;
    sa = ua[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
    sb = ub[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
    maxv = (longint'(1) << (w - 1)) - 1;
    minv = -(longint'(1) << (w - 1));
    case (op)
      2'd0: kind = 0;
      2'd1: kind = 1;
      2'd2: kind = 4;
      default: begin
        case (fn)
          6'b000001: kind = 0;
          6'b000010: kind = 1;
          6'b000100: kind = 2;
          6'b001000: kind = 3;
          6'b010000: kind = 4;
          6'b100000: kind = has_mul ? 5 : 6;
          default:   kind = 6;
        endcase
      end
    endcase
    res = '0; ovf = 0; err = 0; is_mul = 0;
    case (kind)
      0: begin s = sa + sb; res = (ua + ub) & mask; ovf = (s > maxv) || (s < minv); end
      1: begin s = sa - sb; res = (ua - ub) & mask; ovf = (s > maxv) || (s < minv); end
      2: res = ua & ub;
      3: res = ua | ub;
      4: res = (sa < sb) ? 64'd1 : 64'd0;
      5: begin res = (ua * ub) & mask; is_mul = 1; end
      default: err = 1;
    endcase
  endfunction

  task automatic drive(input bit use8, input bit st, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    if (use8) begin
      bus8.start = st; bus8.alu_op = op; bus8.funct = fn; bus8.a = a[7:0]; bus8.b = b[7:0];
    end else begin
      bus32.start = st; bus32.alu_op = op; bus32.funct = fn; bus32.a = a; bus32.b = b;
    end
  endtask

  function automatic logic get_done(input bit use8);
    return use8 ? bus8.done : bus32.done;
  endfunction

  task automatic read_out(input bit use8, output logic [63:0] r, output logic z, output logic o,
                          output logic e, output logic bz);
    if (use8) begin
      r = {56'd0, bus8.result}; z = bus8.zero; o = bus8.ovf; e = bus8.err; bz = bus8.busy;
    end else begin
      r = {32'd0, bus32.result}; z = bus32.zero; o = bus32.ovf; e = bus32.err; bz = bus32.busy;
    end
  endtask

  // Issue one op, wait (bounded) for done, compare against the model.
  // Sample count: first sample after the accepting edge is 1; single-cycle ops
  // report done there, MUL reports done after WIDTH further edges.
  task automatic run_check(input string tag, input bit use8, input logic [1:0] op,
                           input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] er, r;
    bit eo, ee, em;
    logic z, o, e, bz;
    int lat, w;
    w = use8 ? 8 : 32;
    model(w, !use8, op, fn, {32'd0, a}, {32'd0, b}, er, eo, ee, em);
    @(negedge clk);
    drive(use8, 1'b1, op, fn, a, b);
    @(negedge clk);
    drive(use8, 1'b0, op, fn, a, b);
    lat = 1;
    while (!get_done(use8) && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    read_out(use8, r, z, o, e, bz);
    chk({tag, " latency"}, 64'(lat), em ? 64'(w + 1) : 64'd1);
    chk({tag, " result"}, r, er);
    chk({tag, " zero"}, {63'd0, z}, {63'd0, er == 64'd0});
    chk({tag, " ovf"}, {63'd0, o}, {63'd0, eo});
    chk({tag, " err"}, {63'd0, e}, {63'd0, ee});
    chk({tag, " busy"}, {63'd0, bz}, 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " r32 result"}, {32'd0, bus32.result}, 64'd0);
    chk({tag, " r32 zero"}, {63'd0, bus32.zero}, 64'd1);
    chk({tag, " r32 ovf"}, {63'd0, bus32.ovf}, 64'd0);
    chk({tag, " r32 err"}, {63'd0, bus32.err}, 64'd0);
    chk({tag, " r32 busy"}, {63'd0, bus32.busy}, 64'd0);
    chk({tag, " r32 done"}, {63'd0, bus32.done}, 64'd0);
    chk({tag, " r8 result"}, {56'd0, bus8.result}, 64'd0);
    chk({tag, " r8 zero"}, {63'd0, bus8.zero}, 64'd1);
  endtask

  localparam logic [5:0] FADD = 6'b000001, FSUB = 6'b000010, FAND = 6'b000100;
  localparam logic [5:0] FOR  = 6'b001000, FSLT = 6'b010000, FMUL = 6'b100000;

  initial begin
    logic [5:0] fns [6];
    int lat, busy_cyc, dn;
    logic [1:0] rop;
    logic [5:0] rfn;
    logic [31:0] ra, rb;

    fns[0] = FADD; fns[1] = FSUB; fns[2] = FAND; fns[3] = FOR; fns[4] = FSLT; fns[5] = FMUL;
    drive(1'b0, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Back-to-back table, one start per cycle
    vecs.push_back(mk(2'b11, FADD, 32'd7, 32'd5, 32'd12, 0, 0, 0));
    vecs.push_back(mk(2'b11, FSUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0, 0));
    vecs.push_back(mk(2'b11, FAND, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0, 0));
    vecs.push_back(mk(2'b11, FOR, 32'hF0F0, 32'hFF00, 32'hFFF0, 0, 0, 0));
    vecs.push_back(mk(2'b11, FSLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 0));
    vecs.push_back(mk(2'b11, FADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 1, 0));
    vecs.push_back(mk(2'b11, FSUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1, 0));
    vecs.push_back(mk(2'b11, FSUB, 32'd9, 32'd9, 32'd0, 1, 0, 0));
    vecs.push_back(mk(2'b11, 6'b000011, 32'd4, 32'd4, 32'd0, 1, 0, 1));
    vecs.push_back(mk(2'b11, FADD, 32'd1, 32'd2, 32'd3, 0, 0, 0));
    vecs.push_back(mk(2'b11, 6'b000000, 32'd1, 32'd2, 32'd0, 1, 0, 1));
    vecs.push_back(mk(2'b11, 6'b100001, 32'd1, 32'd2, 32'd0, 1, 0, 1));
    vecs.push_back(mk(2'b00, FSUB, 32'd10, 32'd20, 32'd30, 0, 0, 0));
    vecs.push_back(mk(2'b01, FADD, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 0, 0));
    vecs.push_back(mk(2'b10, FADD, 32'd5, 32'hFFFF_FFFE, 32'd0, 1, 0, 0));
    vecs.push_back(mk(2'b01, FADD, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 0));

    @(negedge clk);
    drive(1'b0, 1'b1, vecs[0].op, vecs[0].fn, vecs[0].a, vecs[0].b);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d done", i), {63'd0, bus32.done}, 64'd1);
      chk($sformatf("vec%0d result", i), {32'd0, bus32.result}, {32'd0, vecs[i].res});
      chk($sformatf("vec%0d zero", i), {63'd0, bus32.zero}, {63'd0, vecs[i].z});
      chk($sformatf("vec%0d ovf", i), {63'd0, bus32.ovf}, {63'd0, vecs[i].o});
      chk($sformatf("vec%0d err", i), {63'd0, bus32.err}, {63'd0, vecs[i].e});
      if (i + 1 < vecs.size())
        drive(1'b0, 1'b1, vecs[i+1].op, vecs[i+1].fn, vecs[i+1].a, vecs[i+1].b);
      else
        drive(1'b0, 1'b0, 2'd0, 6'd0, 32'd0, 32'd0);
    end
    @(negedge clk);
    chk("table done drops", {63'd0, bus32.done}, 64'd0);

    // MUL with ignored start pulses while busy
    drive(1'b0, 1'b1, 2'b11, FMUL, 32'h0001_2345, 32'h0000_0100);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b11, FMUL, 32'd0, 32'd0);
    lat = 1;
    busy_cyc = 0;
    while (!bus32.done && lat < 64) begin
      if (bus32.busy) busy_cyc++;
      if (lat == 3 || lat == 10 || lat == 20) drive(1'b0, 1'b1, 2'b00, FADD, 32'd1, 32'd1);
      else                                   drive(1'b0, 1'b0, 2'b00, FADD, 32'd1, 32'd1);
      @(negedge clk);
      lat++;
    end
    drive(1'b0, 1'b0, 2'b00, FADD, 32'd0, 32'd0);
    chk("mul busy cycles", 64'(busy_cyc), 64'd32);
    chk("mul latency", 64'(lat), 64'd33);
    chk("mul busy at done", {63'd0, bus32.busy}, 64'd0);
    chk("mul result", {32'd0, bus32.result}, 64'h0123_4500);
    chk("mul err", {63'd0, bus32.err}, 64'd0);
    @(negedge clk);
    chk("mul no queued op", {63'd0, bus32.done}, 64'd0);
    chk("mul result held", {32'd0, bus32.result}, 64'h0123_4500);

    run_check("mul -3x7", 1'b0, 2'b11, FMUL, 32'hFFFF_FFFD, 32'd7);
    chk("mul -3x7 value", {32'd0, bus32.result}, 64'hFFFF_FFEB);

    // New start accepted in the cycle done is high
    drive(1'b0, 1'b1, 2'b11, FMUL, 32'd6, 32'd7);
    lat = 0;
    do begin @(negedge clk); lat++; if (lat == 1) drive(1'b0, 1'b0, 2'b00, 6'd0, 32'd0, 32'd0); end
    while (!bus32.done && lat < 64);
    chk("mul 6x7", {32'd0, bus32.result}, 64'd42);
    drive(1'b0, 1'b1, 2'b11, FADD, 32'd2, 32'd2);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    chk("start in done cycle done", {63'd0, bus32.done}, 64'd1);
    chk("start in done cycle result", {32'd0, bus32.result}, 64'd4);

    // Reset during MUL at cycle 5 of 32
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b11, FMUL, 32'd5, 32'd3);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    chk("pre-reset busy", {63'd0, bus32.busy}, 64'd1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid-mul reset");
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.done || bus32.busy) dn++;
    end
    chk("no done after abort", 64'(dn), 64'd0);
    run_check("add after reset", 1'b0, 2'b11, FADD, 32'd100, 32'd23);

    // 8-bit build without MUL
    run_check("w8 mul illegal", 1'b1, 2'b11, FMUL, 32'd3, 32'd4);
    run_check("w8 add ovf", 1'b1, 2'b11, FADD, 32'h70, 32'h10);
    chk("w8 add ovf value", {56'd0, bus8.result}, 64'h80);
    chk("w8 ovf flag", {63'd0, bus8.ovf}, 64'd1);

    // Randomized against the reference model
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom_range(0, 3));
      rfn = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 5)] : 6'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 32'h7FFF_FFFF;
        1: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
      run_check($sformatf("rnd32_%0d", i), 1'b0, rop, rfn, ra, rb);
    end
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      rfn = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 5)] : 6'($urandom);
      run_check($sformatf("rnd8_%0d", i), 1'b1, rop, rfn, $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
